mb8_acc_td: RTL and testbench

//   Downstream stage of the registered radix-8 Booth multiplier wrapper (mb8 core behind input/output regs).

---
 rtl/mb8_pkg.sv | 14 +
 rtl/mb8_sb_delay.sv | 20 ++
 rtl/mb8_acc_td.sv | 92 +++++++++
 tb/tb_mb8_acc_td.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mb8_pkg.sv
// mb8_pkg: shared types and constants for stages hung off the mb8 Booth multiplier
package mb8_pkg;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;
  localparam int PW_D = 16;
  localparam int AW_D = 32;
  localparam int LAT_D = 2;
  localparam int CW_D = 8;
  function automatic logic signed [63:0] SAT_MAX(input int aw);
    return (64'sd1 <<< (aw - 1)) - 64'sd1;
  endfunction
  function automatic logic signed [63:0] SAT_MIN(input int aw);
    return -(64'sd1 <<< (aw - 1));
  endfunction
endpackage

// File: rtl/mb8_sb_delay.sv
// mb8_sb_delay: LAT-deep 2-bit sideband shift register, aligns valid/last with the product
module mb8_sb_delay #(
  parameter int LAT = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] d_i,
  output logic [1:0] q_o
);
  logic [1:0] sr_q [LAT];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LAT; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < LAT; i++) sr_q[i] <= sr_q[i-1];
    end
  end
  assign q_o = sr_q[LAT-1];
endmodule

// File: rtl/mb8_acc_td.sv
// mb8_acc_td: accumulates the multiplier product stream into a per-burst dot product
// and presents the sum, beat count and overflow flag on a valid/ready port.
module mb8_acc_td
  import mb8_pkg::*;
#(
  parameter int PW  = PW_D,
  parameter int AW  = AW_D,
  parameter int LAT = LAT_D,
  parameter int CW  = CW_D,
  parameter bit SAT = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  input  logic [PW-1:0] product,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [AW-1:0] res_data,
  output logic [CW-1:0] res_count,
  output logic          res_ovf
);
  localparam logic [AW-1:0] MAXV = AW'(SAT_MAX(AW));
  localparam logic [AW-1:0] MINV = AW'(SAT_MIN(AW));
  state_e        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d, res_data_q;
  logic [CW-1:0] cnt_q, cnt_d, res_count_q;
  logic          ovf_q, ovf_d, res_ovf_q, rdy_q, rdy_d;
  logic          beat, a_valid, a_last, of;
  logic [AW:0]   sum;
  logic [AW-1:0] nxt;
  assign beat = in_valid & rdy_q;
  mb8_sb_delay #(.LAT(LAT)) u_dly (
    .clk_i (CLK),
    .rst_ni(RST),
    .d_i   ({beat, beat & in_last}),
    .q_o   ({a_valid, a_last})
  );
  // acc/cnt/ovf are zero whenever IDLE, so the first beat needs no separate load path
  assign sum = {acc_q[AW-1], acc_q} + {{(AW + 1 - PW){product[PW-1]}}, product};
  assign of  = sum[AW] ^ sum[AW-1];
  assign nxt = (SAT && of) ? (sum[AW] ? MINV : MAXV) : sum[AW-1:0];
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    rdy_d   = (beat && in_last) ? 1'b0 : (res_valid && res_ready) ? 1'b1 : rdy_q;
    if (state_q == DONE) begin
      if (res_ready) begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    end else if (a_valid) begin
      acc_d   = nxt;
      cnt_d   = cnt_q + CW'(1);
      ovf_d   = ovf_q | of;
      state_d = a_last ? DONE : ACC;
    end
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      rdy_q       <= 1'b1;
      res_data_q  <= '0;
      res_count_q <= '0;
      res_ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rdy_q   <= rdy_d;
      if (state_q != DONE && state_d == DONE) begin
        res_data_q  <= acc_d;
        res_count_q <= cnt_d;
        res_ovf_q   <= ovf_d;
      end
    end
  end
  assign in_ready  = rdy_q;
  assign res_valid = (state_q == DONE);
  assign res_data  = res_data_q;
  assign res_count = res_count_q;
  assign res_ovf   = res_ovf_q;
endmodule

// File: tb/tb_mb8_acc_td.sv
// tb_mb8_acc_td: scoreboard bench driving a registered multiplier model into three accumulator configs
module tb_mb8_acc_td;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic in_valid = 1'b0, in_last = 1'b0, res_ready = 1'b1;
  logic signed [7:0]  mx = '0, my = '0, mx_q, my_q;
  logic signed [15:0] prod;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mx_q <= '0;
      my_q <= '0;
      prod <= '0;
    end else begin
      mx_q <= mx;
      my_q <= my;
      prod <= mx_q * my_q;
    end
  end
  logic        rdy32, rdys, rdyw, rv32, rvs, rvw, ovf32, ovfs, ovfw;
  logic [31:0] data32;
  logic [15:0] datas, dataw;
  logic [7:0]  cnt32, cnts, cntw;
  mb8_acc_td #(.AW(32), .SAT(1'b1)) u32 (
    .CLK(clk), .RST(rst_n), .in_valid(in_valid), .in_last(in_last), .in_ready(rdy32),
    .product(prod), .res_valid(rv32), .res_ready(res_ready), .res_data(data32),
    .res_count(cnt32), .res_ovf(ovf32));
  mb8_acc_td #(.AW(16), .SAT(1'b1)) us (
    .CLK(clk), .RST(rst_n), .in_valid(in_valid), .in_last(in_last), .in_ready(rdys),
    .product(prod), .res_valid(rvs), .res_ready(res_ready), .res_data(datas),
    .res_count(cnts), .res_ovf(ovfs));
  mb8_acc_td #(.AW(16), .SAT(1'b0)) uw (
    .CLK(clk), .RST(rst_n), .in_valid(in_valid), .in_last(in_last), .in_ready(rdyw),
    .product(prod), .res_valid(rvw), .res_ready(res_ready), .res_data(dataw),
    .res_count(cntw), .res_ovf(ovfw));
  typedef struct {
    logic [31:0] d32;
    logic [15:0] ds;
    logic [15:0] dw;
    logic [7:0]  cnt;
    logic [2:0]  ovf;
  } exp_t;
  exp_t q[$];
  exp_t e_m;
  int tests = 0, fails = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic expect_res(input logic [31:0] d32, input logic [15:0] ds, input logic [15:0] dw,
                            input logic [7:0] c, input logic [2:0] o);
    q.push_back('{d32, ds, dw, c, o});
  endtask
  always @(negedge clk) begin
    if (rst_n && rv32 && res_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", data32, 32'hx);
      end else begin
        e_m = q.pop_front();
        chk("data32", data32, e_m.d32);
        chk("data16_sat", 32'(datas), 32'(e_m.ds));
        chk("data16_wrap", 32'(dataw), 32'(e_m.dw));
        chk("count", {8'h0, cnt32, cnts, cntw}, {8'h0, e_m.cnt, e_m.cnt, e_m.cnt});
        chk("ovf", 32'({ovf32, ovfs, ovfw}), 32'(e_m.ovf));
        chk("valid16", 32'({rvs, rvw}), 32'd3);
      end
    end
  end
  task automatic send(input logic signed [7:0] a, input logic signed [7:0] b, input logic last);
    int n = 0;
    while (!rdy32 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy32) chk("send_timeout", 32'(rdy32), 32'd1);
    in_valid = 1'b1;
    in_last  = last;
    mx       = a;
    my       = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    mx       = 8'($urandom_range(1, 127));
    my       = 8'($urandom_range(1, 127));
  endtask
  task automatic wait_rv(input string n);
    int k = 0;
    while (!rv32 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({n, "_rv"}, 32'(rv32), 32'd1);
  endtask
  task automatic wait_drain(input string n);
    int k = 0;
    while ((q.size() != 0 || rv32) && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({n, "_drain"}, 32'(q.size()), 32'd0);
  endtask
  task automatic chk_reset(input string n);
    chk({n, "_in_ready"}, 32'({rdy32, rdys, rdyw}), 32'd7);
    chk({n, "_res_valid"}, 32'({rv32, rvs, rvw}), 32'd0);
    chk({n, "_res_data"}, data32, 32'd0);
    chk({n, "_res_count"}, 32'(cnt32), 32'd0);
    chk({n, "_res_ovf"}, 32'({ovf32, ovfs, ovfw}), 32'd0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_res(32'd30, 16'd30, 16'd30, 8'd4, 3'b000);
    send(1, 1, 0);
    send(2, 2, 0);
    send(3, 3, 0);
    send(4, 4, 1);
    chk("t1_ready_low", 32'(rdy32), 32'd0);
    @(posedge clk);
    #1;
    chk("t1_rv_early", 32'(rv32), 32'd0);
    @(posedge clk);
    #1;
    chk("t1_latency", 32'(rv32), 32'd1);
    wait_drain("t1");
    res_ready = 1'b0;
    expect_res(32'd16384, 16'd16384, 16'd16384, 8'd1, 3'b000);
    send(-128, -128, 1);
    chk("t2_ready_low", 32'(rdy32), 32'd0);
    wait_rv("t2");
    chk("t2_ready_pending", 32'(rdy32), 32'd0);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t2_ready_back", 32'(rdy32), 32'd1);
    chk("t2_rv_drop", 32'(rv32), 32'd0);
    expect_res(32'd48387, 16'h7fff, 16'(-17149), 8'd3, 3'b011);
    send(127, 127, 0);
    send(127, 127, 0);
    send(127, 127, 1);
    wait_drain("t3");
    res_ready = 1'b0;
    expect_res(-32'sd26, 16'(-26), 16'(-26), 8'd2, 3'b000);
    send(5, 6, 0);
    send(-7, 8, 1);
    wait_rv("t4");
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      in_last  = 1'b1;
      mx       = 8'($urandom_range(1, 127));
      my       = 8'($urandom_range(1, 127));
      @(posedge clk);
      #1;
      chk("t4_hold_data", data32, -32'sd26);
      chk("t4_hold_count", 32'(cnt32), 32'd2);
      chk("t4_hold_valid", 32'(rv32), 32'd1);
      chk("t4_no_ready", 32'(rdy32), 32'd0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    res_ready = 1'b1;
    expect_res(32'd9, 16'd9, 16'd9, 8'd1, 3'b000);
    send(3, 3, 1);
    wait_drain("t4");
    send(9, 9, 0);
    send(9, 9, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("t5_async");
    @(posedge clk);
    #1 rst_n = 1'b1;
    expect_res(-32'sd9911, 16'(-9911), 16'(-9911), 8'd4, 3'b000);
    send(10, 10, 0);
    send(-20, 3, 0);
    send(7, 7, 0);
    send(100, -100, 1);
    wait_drain("t5");
    expect_res(-32'sd90, 16'(-90), 16'(-90), 8'd6, 3'b000);
    send(2, 3, 0);
    @(posedge clk);
    #1;
    send(-4, 5, 0);
    @(posedge clk);
    #1;
    send(6, 7, 0);
    @(posedge clk);
    #1;
    send(-8, 9, 0);
    @(posedge clk);
    #1;
    send(10, 11, 0);
    @(posedge clk);
    #1;
    send(-12, 13, 1);
    wait_drain("t6");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
